// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one fixed-latency ALU among NUM_REQ requesters
module alu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ALU_LAT = 1,
  parameter int DW      = 8
) (
  input  logic                  alu_clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_a,
  input  logic [NUM_REQ*DW-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_mode,
  input  logic [NUM_REQ*3-1:0]  req_op,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  rsp_irq,
  output logic                  busy,
  output logic [DW-1:0]         alu_in_a,
  output logic [DW-1:0]         alu_in_b,
  output logic                  alu_mode,
  output logic [2:0]            alu_op_a,
  output logic [2:0]            alu_op_b,
  output logic                  alu_irq_clr,
  input  logic [DW-1:0]         alu_out,
  input  logic                  alu_irq
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ALU_LAT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, CLR} state_t;
  state_t state;
  logic [GW-1:0] last, gnt, pick, idx;
  logic [CW-1:0] cnt;
  logic found;
  // scan downward from the farthest candidate so the nearest one after last wins
  always_comb begin
    pick = last;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << pick : '0;
  always_ff @(posedge alu_clk) begin
    if (rst) begin
      state <= IDLE;
      last <= GW'(NUM_REQ - 1);
      gnt <= '0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_irq <= 1'b0;
      busy <= 1'b0;
      alu_in_a <= '0;
      alu_in_b <= '0;
      alu_mode <= 1'b0;
      alu_op_a <= '0;
      alu_op_b <= '0;
      alu_irq_clr <= 1'b0;
    end else begin
      rsp_valid <= '0;
      alu_irq_clr <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state <= WAIT;
          busy <= 1'b1;
          last <= pick;
          gnt <= pick;
          cnt <= CW'(ALU_LAT);
          alu_in_a <= req_a[pick*DW +: DW];
          alu_in_b <= req_b[pick*DW +: DW];
          alu_mode <= req_mode[pick];
          alu_op_a <= req_mode[pick] ? 3'd0 : req_op[pick*3 +: 3];
          alu_op_b <= req_mode[pick] ? req_op[pick*3 +: 3] : 3'd0;
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_data <= alu_out;
            rsp_irq <= alu_irq;
            rsp_valid <= NUM_REQ'(1) << gnt;
            state <= RESP;
          end
        end
        RESP: begin
          state <= rsp_irq ? CLR : IDLE;
          busy <= rsp_irq;
          alu_irq_clr <= rsp_irq;
        end
        CLR: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed + random stimulus against a cycle-timeline model of the arbiter
module tb_alu_req_arbiter;
  localparam int N = 4, LAT = 3, DW = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready, req_mode, rsp_valid;
  logic [N*DW-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [DW-1:0] rsp_data, alu_in_a, alu_in_b, alu_out, noise = '0;
  logic rsp_irq, busy, alu_mode, alu_irq_clr, alu_irq = 0;
  logic [2:0] alu_op_a, alu_op_b;
  logic [DW-1:0] pa[N], pb[N];
  logic [2:0] po[N];
  logic pm[N];
  int n_cmp = 0, n_bad = 0, irq_pct = 0;
  logic force_irq = 0;

  alu_req_arbiter #(.NUM_REQ(N), .ALU_LAT(LAT), .DW(DW)) dut (
    .alu_clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_irq(rsp_irq), .busy(busy),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_mode(alu_mode),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_irq_clr(alu_irq_clr),
    .alu_out(alu_out), .alu_irq(alu_irq));

  always_comb
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = pa[i];
      req_b[i*DW +: DW] = pb[i];
      req_mode[i] = pm[i];
      req_op[i*3 +: 3] = po[i];
    end

  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a, b, input logic md, input logic [2:0] op);
    logic [DW-1:0] x, y;
    x = md ? b : a;
    y = md ? a : b;
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << 1;
      3'd6: return x >> 1;
      default: return ~x;
    endcase
  endfunction

  // Model: a transaction granted in cycle hs occupies the ALU until free_at
  int cyc = 0, free_at = 0, hs = -100, clr_at = -100, last = N - 1, g = 0, pick;
  logic [DW-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic [2:0] m_op = '0;
  logic m_mode = 0, m_irq = 0;
  logic [N-1:0] e_ready, acc_mask = '0;
  always_comb begin
    pick = -1;
    for (int k = 1; k <= N && pick < 0; k++)
      if (req_valid[(last + k) % N]) pick = (last + k) % N;
    e_ready = (cyc >= free_at && pick >= 0 && !rst) ? N'(1 << pick) : '0;
  end
  // stand-in ALU: correct result only in the expected capture cycle, noise otherwise
  assign alu_out = (cyc == hs + LAT) ? alu_f(m_a, m_b, m_mode, m_op) : noise;

  always @(posedge clk) begin
    if (rst) begin
      free_at <= cyc + 1; hs <= -100; clr_at <= -100; last <= N - 1; g <= 0;
      m_a <= '0; m_b <= '0; m_op <= '0; m_mode <= 0; m_data <= '0; m_irq <= 0;
    end else begin
      if (e_ready != 0) begin
        g <= pick; last <= pick; hs <= cyc; free_at <= cyc + LAT + 2;
        m_a <= pa[pick]; m_b <= pb[pick]; m_mode <= pm[pick]; m_op <= po[pick];
      end
      if (cyc == hs + LAT) begin
        m_data <= alu_f(m_a, m_b, m_mode, m_op);
        m_irq <= alu_irq;
        if (alu_irq) begin clr_at <= cyc + 2; free_at <= cyc + 3; end
      end
    end
    acc_mask <= e_ready;
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      chk("req_ready", req_ready, e_ready);
      chk("busy", busy, cyc < free_at);
      chk("rsp_valid", rsp_valid, (cyc == hs + LAT + 1) ? (1 << g) : 0);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_irq", rsp_irq, m_irq);
      chk("alu_in_a", alu_in_a, m_a);
      chk("alu_in_b", alu_in_b, m_b);
      chk("alu_mode", alu_mode, m_mode);
      chk("alu_op_a", alu_op_a, m_mode ? 3'd0 : m_op);
      chk("alu_op_b", alu_op_b, m_mode ? m_op : 3'd0);
      chk("alu_irq_clr", alu_irq_clr, cyc == clr_at);
    end

  task automatic step();
    @(posedge clk);
    #1;
    noise = 8'($urandom);
    alu_irq = force_irq ? 1'b1 : ($urandom_range(99) < irq_pct);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 50 && busy; c++) step();
    chk("wait_idle", busy, 0);
  endtask

  task automatic drive_rand();
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i] || (req_valid[i] && $urandom_range(99) < 3)) req_valid[i] = 0;
      else if (!req_valid[i] && $urandom_range(99) < 30) begin
        req_valid[i] = 1;
        pa[i] = 8'($urandom); pb[i] = 8'($urandom);
        pm[i] = 1'($urandom); po[i] = 3'($urandom);
      end
    end
  endtask

  initial begin
    int got[$];
    for (int i = 0; i < N; i++) begin
      pa[i] = 8'($urandom); pb[i] = 8'($urandom); pm[i] = 0; po[i] = 3'($urandom);
    end
    repeat (3) step();
    rst = 0;
    // single request from requester 2
    req_valid = 4'b0100; pa[2] = 8'h12; pb[2] = 8'h34; pm[2] = 0; po[2] = 3'd0;
    #1 chk("p1_ready", req_ready, 4'b0100);
    step(); req_valid = '0;
    chk("p1_in_a", alu_in_a, 8'h12);
    chk("p1_in_b", alu_in_b, 8'h34);
    repeat (LAT) step();
    chk("p1_rsp_valid", rsp_valid, 4'b0100);
    chk("p1_rsp_data", rsp_data, 8'h46);
    chk("p1_rsp_irq", rsp_irq, 0);
    // all requesters held valid: strict rotation from 0
    rst = 1; step(); rst = 0;
    req_valid = '1;
    for (int c = 0; c < 200 && got.size() < 8; c++) begin
      #1;
      for (int i = 0; i < N; i++) if (req_ready[i]) got.push_back(i);
      step();
    end
    req_valid = '0;
    chk("p2_count", got.size(), 8);
    for (int k = 0; k < got.size(); k++) chk("p2_grant", got[k], k % N);
    // interrupt at capture delays the next grant by the clear cycle
    wait_idle();
    force_irq = 1; alu_irq = 1;
    req_valid = 4'b0010;
    #1 chk("p3_ready", req_ready, 4'b0010);
    step(); req_valid = 4'b1000;
    repeat (LAT) step();
    chk("p3_rsp_valid", rsp_valid, 4'b0010);
    chk("p3_rsp_irq", rsp_irq, 1);
    chk("p3_ready_resp", req_ready, 0);
    step();
    chk("p3_clr", alu_irq_clr, 1);
    chk("p3_ready_clr", req_ready, 0);
    step();
    chk("p3_ready_next", req_ready, 4'b1000);
    step(); req_valid = '0; force_irq = 0;
    // mode 1, opcode 3 held for the full latency
    wait_idle();
    req_valid = 4'b0001; pa[0] = 8'h21; pb[0] = 8'h07; pm[0] = 1; po[0] = 3'd3;
    step(); req_valid = '0;
    for (int c = 0; c < LAT; c++) begin
      chk("p4_op_a", alu_op_a, 0);
      chk("p4_op_b", alu_op_b, 3);
      chk("p4_mode", alu_mode, 1);
      chk("p4_in_a", alu_in_a, 8'h21);
      step();
    end
    chk("p4_rsp_valid", rsp_valid, 4'b0001);
    chk("p4_rsp_data", rsp_data, 8'h27);
    // reset while waiting on the ALU
    wait_idle();
    req_valid = 4'b0100; pa[2] = 8'hA5; pb[2] = 8'h5A; pm[2] = 0; po[2] = 3'd1;
    step(); req_valid = '0;
    rst = 1; step(); rst = 0;
    chk("p5_busy", busy, 0);
    chk("p5_in_a", alu_in_a, 0);
    for (int c = 0; c < LAT + 2; c++) begin
      chk("p5_no_rsp", rsp_valid, 0);
      chk("p5_no_clr", alu_irq_clr, 0);
      step();
    end
    req_valid = '1;
    #1 chk("p5_first", req_ready, 4'b0001);
    step(); req_valid = '0;
    // requester 1 withdraws while 0 is served
    rst = 1; step(); rst = 0;
    req_valid = 4'b0011;
    #1 chk("p6_ready", req_ready, 4'b0001);
    step(); req_valid = '0;
    for (int c = 0; c < LAT + 1; c++) begin
      chk("p6_no_ready", req_ready, 0);
      chk("p6_busy", busy, 1);
      step();
    end
    chk("p6_busy_low", busy, 0);
    // random traffic with random interrupts and occasional resets
    irq_pct = 25;
    repeat (3000) begin
      step();
      drive_rand();
      rst = ($urandom_range(499) == 0);
    end
    rst = 0; req_valid = '0;
    repeat (10) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter that shares the single ALU among NUM_REQ requesters. Accepts one operation at a time over a per-requester valid/ready handshake, drives the ALU operand/mode/opcode inputs, waits the fixed ALU latency, and returns the result and interrupt flag to the granted requester. When the ALU raises `alu_irq`, the block sequences `alu_irq_clr` itself. Sits between the requesters and the ALU input/output signals.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ALU_LAT, 1, cycles from operands applied to `alu_out`/`alu_irq` valid (1..4)
- DW, 8, operand/result width
- alu_clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_a  in  NUM_REQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NUM_REQ*DW  operand B, same packing
- req_mode  in  NUM_REQ  0 = op_a set, 1 = op_b set
- req_op  in  NUM_REQ*3  opcode within selected set
- rsp_valid  out  NUM_REQ  one-cycle result strobe to the granted requester
- rsp_data  out  DW  result, valid with any `rsp_valid` bit
- rsp_irq  out  1  ALU interrupt seen with this result
- busy  out  1  high in any state other than IDLE
- alu_in_a, alu_in_b  out  DW  registered operands to ALU
- alu_mode  out  1  registered mode
- alu_op_a, alu_op_b  out  3  registered opcodes; unselected set driven 0
- alu_irq_clr  out  1  one-cycle interrupt clear pulse
- alu_out  in  DW  ALU result
- alu_irq  in  1  ALU interrupt

## Operation
- States: IDLE, WAIT, RESP, CLR.
- IDLE: if any `req_valid`, grant g = first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping. `req_ready[g]`=1 combinationally in this cycle only. On the edge: load `alu_in_a/b`, `alu_mode`, opcodes from requester g; `alu_op_a`=op, `alu_op_b`=0 when mode 0, reverse when mode 1; last_grant<=g; cnt<=ALU_LAT; go WAIT.
- No `req_valid`: stay IDLE, `req_ready`=0.
- WAIT: ALU inputs held constant; cnt decrements each cycle; in the cycle cnt==1, capture `alu_out` to `rsp_data` and `alu_irq` to `rsp_irq`; go RESP.
- RESP: `rsp_valid[g]`=1 for one cycle; `rsp_data`/`rsp_irq` hold until the next capture. If `rsp_irq`=1 go CLR, else IDLE.
- CLR: `alu_irq_clr`=1 for exactly one cycle; go IDLE.
- Requesters hold `req_valid` and payload until `req_ready`; dropping `req_valid` early is legal and simply forfeits arbitration. Payload changes while not granted are ignored.
- `req_ready` never asserted outside IDLE; requests arriving in WAIT/RESP/CLR wait.
- Opcodes passed unchanged; no legality check.

## Timing
- Reset: state IDLE, last_grant = NUM_REQ-1 (requester 0 wins first), all outputs 0: `req_ready`, `rsp_valid`, `rsp_data`, `rsp_irq`, `busy`, `alu_in_*`, `alu_mode`, `alu_op_*`, `alu_irq_clr`.
- Handshake in cycle T; ALU inputs valid T+1..T+ALU_LAT; capture at end of T+ALU_LAT; `rsp_valid` in T+ALU_LAT+1.
- Next grant earliest T+ALU_LAT+2 (no irq) or T+ALU_LAT+3 (irq).
- `busy`=1 from T+1 through last RESP/CLR cycle.
- All requesters valid: grant order strictly rotates 0,1,..,NUM_REQ-1,0.
- `alu_irq` sampled only in the capture cycle; assertions at other times ignored.
- Reset mid-operation: next cycle IDLE, outputs at reset values; in-flight result discarded, no `rsp_valid`, no `alu_irq_clr`.

## Test plan
- Reset then single request: req 2 valid, a=8'h12, b=8'h34, mode 0, op 0 (add), ALU_LAT=1 -> `req_ready[2]` same cycle, `alu_in_a/b`=12/34 next cycle, `rsp_valid[2]` 2 cycles after handshake, `rsp_data`=8'h46, `rsp_irq`=0.
- All four requesters held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each `rsp_valid` one-hot to the matching requester.
- ALU asserts `alu_irq` at capture -> `rsp_irq`=1 with `rsp_valid`, `alu_irq_clr` pulse the following cycle, next `req_ready` one cycle later than the no-irq case.
- ALU_LAT=3, mode 1, op 3 -> `alu_op_a`=0, `alu_op_b`=3, inputs stable 3 cycles, `rsp_valid` 4 cycles after handshake.
- `rst` asserted during WAIT -> no `rsp_valid`, all outputs 0 next cycle, requester 0 granted first afterwards.
- req 1 drops `req_valid` while req 0 is served -> req 1 never granted, `busy` falls after RESP.
